rs232_bus_master: RTL and testbench

Serial-to-bus bridge that acts as bus initiator on the CPU memory bus. Byte frames arrive from an `async_receiver`; the block decodes read/write commands, drives `read_q`/`write_q` with address and data, waits for `read_dn`/`write_dn`, and returns an ack or read data through an `async_transmitter`. It is the initiator-side counterpart to memory-mapped peripherals on the same bus, used for host-driven debug, memory load and inspection.

---
 rtl/rs232_bus_master.sv | 138 +++++++++++++
 tb/tb_rs232_bus_master.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rs232_bus_master.sv
// rs232_bus_master: serial-frame to bus-initiator bridge returning ack/data bytes.
// Define RS232_BUS_MASTER_AUTOINC_EN to enable the auto-incrementing address commands 0x77/0x72.
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
module rs232_bus_master #(
    parameter int ADDR_W      = `ADDR_SIZE,
    parameter int DATA_W      = `DATA_SIZE,
    parameter int RX_TIMEOUT  = 100000,
    parameter int BUS_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_oe,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              read_q,
    output logic              write_q,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_dn,
    input  logic              write_dn,
    output logic              busy,
    output logic              rx_overrun
);
    localparam int AB = ADDR_W / 8;
    localparam int DB = DATA_W / 8;
    typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, BUS_REQ, SEND, TX_WAIT} state_t;
    state_t state, state_n;
    logic is_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data, resp;
    logic [7:0] cnt, rem;
    logic [31:0] tmo;
    logic done, tmo_hit, tmo_run, cmd_w, cmd_r, cmd_wa, cmd_ra;
    assign cmd_w = rx_byte == 8'h57;
    assign cmd_r = rx_byte == 8'h52;
`ifdef RS232_BUS_MASTER_AUTOINC_EN
    assign cmd_wa = rx_byte == 8'h77;
    assign cmd_ra = rx_byte == 8'h72;
`else
    assign cmd_wa = 1'b0;
    assign cmd_ra = 1'b0;
`endif
    assign done     = is_write ? write_dn : read_dn;
    // One counter serves both the inter-byte and the bus timeout; it restarts on every state change
    assign tmo_run  = (state == GET_ADDR || state == GET_DATA) ? !rx_valid : state == BUS_REQ;
    assign tmo_hit  = tmo == 32'((state == BUS_REQ ? BUS_TIMEOUT : RX_TIMEOUT) - 1);
    assign read_q   = state == BUS_REQ && !is_write;
    assign write_q  = state == BUS_REQ && is_write;
    assign addr_out = state == BUS_REQ ? addr : '0;
    assign data_out = write_q ? data : '0;
    assign busy     = state != IDLE;
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (rx_valid)
                    state_n = (cmd_w || cmd_r) ? GET_ADDR : cmd_wa ? GET_DATA : cmd_ra ? BUS_REQ : SEND;
            end
            GET_ADDR: begin
                if (rx_valid)
                    state_n = cnt != 8'(AB - 1) ? GET_ADDR : is_write ? GET_DATA : BUS_REQ;
                else if (tmo_hit)
                    state_n = IDLE;
            end
            GET_DATA: begin
                if (rx_valid)
                    state_n = cnt != 8'(DB - 1) ? GET_DATA : BUS_REQ;
                else if (tmo_hit)
                    state_n = IDLE;
            end
            BUS_REQ: state_n = (done || tmo_hit) ? SEND : BUS_REQ;
            SEND:    state_n = tx_busy ? SEND : TX_WAIT;
            TX_WAIT: state_n = (tx_start || tx_busy) ? TX_WAIT : rem == 8'd0 ? IDLE : SEND;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            is_write   <= 1'b0;
            addr       <= '0;
            data       <= '0;
            resp       <= '0;
            cnt        <= '0;
            rem        <= '0;
            tmo        <= '0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= clk_oe && rx_valid && (state == BUS_REQ || state == SEND || state == TX_WAIT);
            if (clk_oe) begin
                state <= state_n;
                tmo   <= (tmo_run && state_n == state) ? tmo + 32'd1 : '0;
                cnt   <= state_n != state ? '0 : cnt + 8'(rx_valid && (state == GET_ADDR || state == GET_DATA));
                if (state == IDLE && rx_valid) begin
                    is_write <= cmd_w || cmd_wa;
                    resp     <= DATA_W'(8'h3F) << (DATA_W - 8);
                    rem      <= '0;
                end
                if (state == GET_ADDR && rx_valid)
                    addr <= (addr << 8) | ADDR_W'(rx_byte);
                if (state == GET_DATA && rx_valid)
                    data <= (data << 8) | DATA_W'(rx_byte);
                if (state == BUS_REQ && done) begin
                    resp <= is_write ? DATA_W'(8'h4B) << (DATA_W - 8) : data_in;
                    rem  <= is_write ? 8'd0 : 8'(DB - 1);
`ifdef RS232_BUS_MASTER_AUTOINC_EN
                    addr <= addr + ADDR_W'(DB);
`endif
                end else if (state == BUS_REQ && tmo_hit) begin
                    resp <= DATA_W'(8'h45) << (DATA_W - 8);
                    rem  <= '0;
                end
                // Response bytes leave from the top of resp, so multi-byte reads go out MSB first
                if (state == SEND && !tx_busy) begin
                    tx_start <= 1'b1;
                    tx_data  <= resp[DATA_W-1 -: 8];
                    resp     <= resp << 8;
                end
                if (state == TX_WAIT) begin
                    tx_start <= 1'b0;
                    if (!tx_start && !tx_busy && rem != 8'd0)
                        rem <= rem - 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_rs232_bus_master.sv
// tb_rs232_bus_master: directed frames into rs232_bus_master with hand-computed responses.
`timescale 1ns/1ps
module tb_rs232_bus_master;
    logic clk = 0, rst = 1, clk_oe = 1, rx_valid = 0, tx_busy = 0, read_dn = 0, write_dn = 0;
    logic [7:0] rx_byte = 0;
    logic [31:0] data_in = 0;
    logic tx_start, read_q, write_q, busy, rx_overrun;
    logic [7:0] tx_data;
    logic [31:0] addr_out, data_out;
    logic [7:0] txq[$];
    int vectors = 0, miscompares = 0, ovr = 0, n = 0;
    always #5 clk = ~clk;
    rs232_bus_master #(.ADDR_W(32), .DATA_W(32), .RX_TIMEOUT(200), .BUS_TIMEOUT(1024)) dut (
        .clk(clk), .rst(rst), .clk_oe(clk_oe), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data), .read_q(read_q),
        .write_q(write_q), .addr_out(addr_out), .data_out(data_out), .data_in(data_in),
        .read_dn(read_dn), .write_dn(write_dn), .busy(busy), .rx_overrun(rx_overrun)
    );
    always @(negedge clk) begin
        if (tx_start) txq.push_back(tx_data);
        if (rx_overrun) ovr++;
    end
    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step(input int k = 1);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic send(input logic [7:0] b);
        rx_byte = b;
        rx_valid = 1;
        step();
        rx_valid = 0;
    endtask
    task automatic send_frame(input logic [71:0] f, input int len);
        for (int i = len - 1; i >= 0; i--) send(f[i*8 +: 8]);
    endtask
    task automatic wait_tx(input string tag, input int cnt);
        for (int i = 0; i < 50 && txq.size() < cnt; i++) step();
        check({tag, " tx count"}, txq.size(), cnt);
    endtask
    task automatic wait_idle(input string tag);
        for (int i = 0; i < 50 && busy; i++) step();
        check({tag, " idle"}, busy, 0);
    endtask
    initial begin
        step(3);
        check("reset outputs", {tx_start, tx_data, read_q, write_q, addr_out, data_out, busy, rx_overrun}, 0);
        rst = 0;
        clk_oe = 0;
        send(8'h57);
        step(2);
        check("gated byte ignored", busy, 0);
        clk_oe = 1;
        // write, done 3 cycles after request, transmitter busy holds the ack back
        send_frame(72'h57_0000_1000_DEAD_BEEF, 9);
        check("wr req", {write_q, read_q}, 2'b10);
        check("wr addr", addr_out, 32'h0000_1000);
        check("wr data", data_out, 32'hDEAD_BEEF);
        tx_busy = 1;
        step(3);
        check("wr hold", write_q, 1);
        write_dn = 1;
        step();
        write_dn = 0;
        check("wr drop", {write_q, addr_out, data_out}, 0);
        step(4);
        check("tx held by busy", txq.size(), 0);
        tx_busy = 0;
        wait_tx("wr", 1);
        check("wr ack", txq[0], 8'h4B);
        wait_idle("wr");
        // read, with a stray write_dn that must be ignored
        txq.delete();
        send_frame(72'h52_0000_2000, 5);
        check("rd req", {write_q, read_q}, 2'b01);
        check("rd addr", addr_out, 32'h0000_2000);
        check("rd data_out zero", data_out, 0);
        n = 0;
        write_dn = 1;
        repeat (6) begin
            n += int'(read_q);
            step();
        end
        write_dn = 0;
        check("rd held", n, 6);
        data_in = 32'h1234_5678;
        read_dn = 1;
        step();
        read_dn = 0;
        data_in = 0;
        check("rd drop", {read_q, addr_out}, 0);
        wait_tx("rd", 4);
        check("rd bytes", {txq[0], txq[1], txq[2], txq[3]}, 32'h1234_5678);
        wait_idle("rd");
        // unknown command, then bytes arriving while responding are dropped
        txq.delete();
        ovr = 0;
        send(8'h41);
        send(8'h52);
        send(8'h52);
        wait_tx("unk", 1);
        check("unk resp", txq[0], 8'h3F);
        wait_idle("unk");
        step(2);
        check("overrun pulses", ovr, 2);
        check("unk single byte", txq.size(), 1);
        // bus timeout
        txq.delete();
        send_frame(72'h52_0000_0040, 5);
        n = 0;
        while (read_q && n < 2000) begin
            n++;
            step();
        end
        check("bus timeout len", n, 1024);
        wait_tx("tmo", 1);
        check("tmo resp", txq[0], 8'h45);
        wait_idle("tmo");
        // partial frame discarded after the inter-byte timeout
        txq.delete();
        send(8'h52);
        send(8'h00);
        step(199);
        check("rx tmo not yet", busy, 1);
        step();
        check("rx tmo expired", busy, 0);
        check("rx tmo silent", txq.size(), 0);
        // full read with done already high on the first request cycle
        send_frame(72'h52_0000_3000, 5);
        read_dn = 1;
        data_in = 32'hA5A5_5A5A;
        check("rd2 req", {read_q, addr_out}, {1'b1, 32'h0000_3000});
        step();
        read_dn = 0;
        data_in = 0;
        check("rd2 min len", read_q, 0);
        wait_tx("rd2", 4);
        check("rd2 bytes", {txq[0], txq[1], txq[2], txq[3]}, 32'hA5A5_5A5A);
        wait_idle("rd2");
        // reset during a bus read
        txq.delete();
        send_frame(72'h52_0000_0008, 5);
        step(2);
        check("rst pre req", read_q, 1);
        rst = 1;
        step();
        check("rst outputs", {tx_start, tx_data, read_q, write_q, addr_out, data_out, busy, rx_overrun}, 0);
        rst = 0;
        step(10);
        check("rst no tx", txq.size(), 0);
        send_frame(72'h57_0000_0010_1122_3344, 9);
        check("post rst wr", {write_q, addr_out, data_out}, {1'b1, 32'h0000_0010, 32'h1122_3344});
        write_dn = 1;
        step();
        write_dn = 0;
        wait_tx("post rst", 1);
        check("post rst ack", txq[0], 8'h4B);
        wait_idle("post rst");
`ifdef RS232_BUS_MASTER_AUTOINC_EN
        txq.delete();
        send_frame(72'h52_0000_00FC, 5);
        check("ai first addr", addr_out, 32'h0000_00FC);
        data_in = 32'hCAFE_F00D;
        read_dn = 1;
        step();
        read_dn = 0;
        wait_tx("ai first", 4);
        wait_idle("ai first");
        txq.delete();
        send(8'h72);
        check("ai second req", {read_q, addr_out}, {1'b1, 32'h0000_0100});
        data_in = 32'h0BAD_BEEF;
        read_dn = 1;
        step();
        read_dn = 0;
        data_in = 0;
        wait_tx("ai second", 4);
        check("ai second bytes", {txq[0], txq[1], txq[2], txq[3]}, 32'h0BAD_BEEF);
        wait_idle("ai second");
`else
        txq.delete();
        send(8'h72);
        wait_tx("no ai 72", 1);
        check("no ai 72 resp", txq[0], 8'h3F);
        wait_idle("no ai 72");
        txq.delete();
        send(8'h77);
        wait_tx("no ai 77", 1);
        check("no ai 77 resp", txq[0], 8'h3F);
        wait_idle("no ai 77");
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
